// File: rtl/mem_ctrl.sv
// Single-port RAM controller arbitrating between an instruction-fetch and a data requester.
// One access in flight; round-robin on ties; fixed read latency RD_LAT.
module mem_ctrl #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [AW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [AW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CntLoad = CW'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = data requester
  logic          last_q, last_d;    // 1 = data granted last
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] f_rdata_q, f_rdata_d;
  logic [AW-1:0] d_rdata_q, d_rdata_d;

  logic pick_d;
  logic grant;

  // Data wins when alone, or on a tie when fetch was granted last.
  assign pick_d = d_req & (~f_req | ~last_q);
  assign grant  = rst_n & (state_q == StIdle) & (f_req | d_req);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = pick_d;
          last_d  = pick_d;
          we_d    = pick_d & d_we;
          addr_d  = pick_d ? d_addr : f_addr;
          wdata_d = pick_d ? d_wdata : '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (owner_q) d_rdata_d = mem_rdata;
          else         f_rdata_d = mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign f_gnt     = grant & ~pick_d;
  assign d_gnt     = grant & pick_d;
  assign f_done    = (state_q == StDone) & ~owner_q;
  assign d_done    = (state_q == StDone) & owner_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = (state_q == StIssue) | (state_q == StWait);
  assign mem_we    = (state_q == StIssue) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances (RD_LAT 2, 1, 7), each with its own RAM model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        f_req [3];
  logic [15:0] f_addr [3];
  logic        f_gnt [3];
  logic        f_done [3];
  logic [15:0] f_rdata [3];
  logic        d_req [3];
  logic        d_we [3];
  logic [15:0] d_addr [3];
  logic [15:0] d_wdata [3];
  logic        d_gnt [3];
  logic        d_done [3];
  logic [15:0] d_rdata [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [15:0] mem_addr [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [15:0] mem [0:65535];
    logic [15:0] pipe [L];

    initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
      mem[16'h0001] = 16'h1234;
      mem[16'h0040] = 16'hCAFE;
    end

    // Read data appears L cycles after the address is presented.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];

    mem_ctrl #(.RD_LAT(L), .AW(16)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_req    (f_req[g]),
      .f_addr   (f_addr[g]),
      .f_gnt    (f_gnt[g]),
      .f_done   (f_done[g]),
      .f_rdata  (f_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_done   (d_done[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input int u, input bit dat, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input bit alt, output int lat,
                        output int en_cnt, output int we_cnt, output bit addr_ok,
                        output logic [15:0] rd);
    int g_c;
    @(posedge clk); #1;
    if (dat) begin
      d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = addr; d_wdata[u] = wdata;
    end else begin
      f_req[u] = 1'b1; f_addr[u] = addr;
    end
    lat = -1; en_cnt = 0; we_cnt = 0; addr_ok = 1'b1; rd = '0; g_c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_c < 0 && (dat ? d_gnt[u] : f_gnt[u])) g_c = i;
      if (mem_en[u]) begin
        en_cnt++;
        if (mem_we[u]) we_cnt++;
        if (mem_addr[u] !== addr) addr_ok = 1'b0;
      end
      if (g_c >= 0 && (dat ? d_done[u] : f_done[u])) begin
        lat = i - g_c;
        rd = dat ? d_rdata[u] : f_rdata[u];
        break;
      end
      @(posedge clk); #1;
      if (alt && g_c >= 0 && !dat) f_addr[u] = 16'h00FF;
    end
    @(posedge clk); #1;
    f_req[u] = 1'b0;
    d_req[u] = 1'b0;
  endtask

  int lat, en_cnt, we_cnt, n_both, n_bad, n_gnts, n_done;
  bit addr_ok, seen;
  logic [15:0] rd;
  logic [3:0] order;

  initial begin
    for (int u = 0; u < 3; u++) begin
      f_req[u] = 0; f_addr[u] = 0; d_req[u] = 0; d_we[u] = 0; d_addr[u] = 0; d_wdata[u] = 0;
    end

    // Reset state, with both requests already high.
    f_req[0] = 1'b1; f_addr[0] = 16'h0001;
    d_req[0] = 1'b1; d_addr[0] = 16'h0040;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", {30'd0, f_gnt[0], d_gnt[0]}, 32'd0);
    check_eq("rst_en", {30'd0, mem_en[0], mem_we[0]}, 32'd0);
    check_eq("rst_addr", {16'd0, mem_addr[0]}, 32'd0);
    check_eq("rst_rdata", {f_rdata[0], d_rdata[0]}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Contention from reset: d, f, d, f.
    order = '0; n_gnts = 0; n_both = 0; n_bad = 0;
    for (int i = 0; i < 40 && n_gnts < 4; i++) begin
      @(negedge clk);
      if (f_gnt[0] && d_gnt[0]) n_both++;
      if (f_done[0] && d_done[0]) n_both++;
      if ((f_gnt[0] || d_gnt[0]) && mem_en[0]) n_bad++;
      if (f_gnt[0] || d_gnt[0]) begin
        order = {order[2:0], d_gnt[0]};
        n_gnts++;
      end
    end
    check_eq("rr_count", n_gnts, 4);
    check_eq("rr_order", {28'd0, order}, 32'b1010);
    check_eq("rr_both", n_both, 0);
    check_eq("rr_overlap", n_bad, 0);

    f_req[0] = 1'b0; d_req[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    // Fetch read, RD_LAT=2.
    access(0, 1'b0, 1'b0, 16'h0001, 16'h0, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("f_rd_lat", lat, 4);
    check_eq("f_rd_en", en_cnt, 3);
    check_eq("f_rd_we", we_cnt, 0);
    check_eq("f_rd_data", {16'd0, rd}, 32'h1234);

    // Data write then read-back.
    access(0, 1'b1, 1'b1, 16'h3000, 16'hBEEF, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("d_wr_lat", lat, 2);
    check_eq("d_wr_en", en_cnt, 1);
    check_eq("d_wr_we", we_cnt, 1);
    check_eq("d_wr_addr", {31'd0, addr_ok}, 32'd1);
    access(0, 1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("d_rd_lat", lat, 4);
    check_eq("d_rd_data", {16'd0, rd}, 32'hBEEF);
    check_eq("f_rdata_hold", {16'd0, f_rdata[0]}, 32'h1234);
    access(0, 1'b0, 1'b0, 16'h3000, 16'h0, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("f_rd_wr_data", {16'd0, rd}, 32'hBEEF);

    // Address change after grant must not disturb the access.
    access(0, 1'b0, 1'b0, 16'h0001, 16'h0, 1'b1, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("latch_addr", {31'd0, addr_ok}, 32'd1);
    check_eq("latch_data", {16'd0, rd}, 32'h1234);

    // Other latencies.
    access(1, 1'b0, 1'b0, 16'h0040, 16'h0, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("lat1_lat", lat, 3);
    check_eq("lat1_data", {16'd0, rd}, 32'hCAFE);
    access(2, 1'b0, 1'b0, 16'h0040, 16'h0, 1'b0, lat, en_cnt, we_cnt, addr_ok, rd);
    check_eq("lat7_lat", lat, 9);
    check_eq("lat7_en", en_cnt, 8);
    check_eq("lat7_data", {16'd0, rd}, 32'hCAFE);

    // Reset during WAIT.
    @(posedge clk); #1;
    f_req[0] = 1'b1; f_addr[0] = 16'h0001;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = f_gnt[0];
    end
    check_eq("rw_gnt", {31'd0, seen}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rw_en", {31'd0, mem_en[0]}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (f_done[0] || d_done[0]) n_done++;
    end
    check_eq("rw_nodone", n_done, 0);
    check_eq("rw_rdata", {16'd0, f_rdata[0]}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_eq("rw_regnt", {31'd0, f_gnt[0]}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = f_done[0];
    end
    check_eq("rw_done", {31'd0, seen}, 32'd1);
    check_eq("rw_data", {16'd0, f_rdata[0]}, 32'h1234);
    @(posedge clk); #1; f_req[0] = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
